// File: rtl/esc_arm_ramp_ctrl_pkg.sv
// Shared types for the ESC arming / slew-rate sequencer.
package esc_ctrl_pkg;

  localparam int SPD_W = 11;

  typedef logic [SPD_W-1:0] spd_t;

  typedef enum logic [1:0] {
    DISARMED  = 2'd0,
    ARM_WAIT  = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

endpackage

// File: rtl/esc_arm_ramp_ctrl_if.sv
// Command/status bundle between the flight controller side and the sequencer.
interface esc_arm_ramp_ctrl_if;
  import esc_ctrl_pkg::*;

  logic arm;
  logic kill;
  spd_t frnt_tgt;
  spd_t bck_tgt;
  spd_t lft_tgt;
  spd_t rght_tgt;
  spd_t frnt_spd;
  spd_t bck_spd;
  spd_t lft_spd;
  spd_t rght_spd;
  logic motors_off;
  logic armed;

  modport master (
    output arm, kill, frnt_tgt, bck_tgt, lft_tgt, rght_tgt,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, motors_off, armed
  );

  modport slave (
    input  arm, kill, frnt_tgt, bck_tgt, lft_tgt, rght_tgt,
    output frnt_spd, bck_spd, lft_spd, rght_spd, motors_off, armed
  );

endinterface

// File: rtl/esc_arm_ramp_ctrl_slew_limiter.sv
// One motor channel: moves the registered speed toward its target by at most
// STEP per tick, never overshooting.
module slew_limiter
  import esc_ctrl_pkg::*;
#(
  parameter spd_t STEP = spd_t'(8)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_clr,
  input  spd_t i_tgt,
  output spd_t o_spd
);

  spd_t                    r_spd;
  logic signed [SPD_W:0]   w_diff;
  logic        [SPD_W:0]   w_mag;
  spd_t                    w_step;
  spd_t                    w_spd_nxt;

  // Sign-retaining difference; its magnitude always fits in SPD_W bits.
  always_comb begin
    w_diff    = $signed({1'b0, i_tgt}) - $signed({1'b0, r_spd});
    w_mag     = w_diff[SPD_W] ? -w_diff : w_diff;
    w_step    = (w_mag > {1'b0, STEP}) ? STEP : w_mag[SPD_W-1:0];
    w_spd_nxt = w_diff[SPD_W] ? (r_spd - w_step) : (r_spd + w_step);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, so it lives inside the clocked block rather than its sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spd <= '0;
    end else if (i_clr) begin
      r_spd <= '0;
    end else if (i_tick) begin
      r_spd <= w_spd_nxt;
    end
  end

  assign o_spd = r_spd;

endmodule

// File: rtl/esc_arm_ramp_ctrl.sv
// Arming sequencer: throttle interlock, arming dwell, per-motor slew limiting,
// ramp-down on disarm and immediate kill.
module esc_arm_ramp_ctrl
  import esc_ctrl_pkg::*;
#(
  parameter int unsigned ARM_CYCLES = 50_000_000,
  parameter int unsigned SLEW_DIV   = 50_000,
  parameter spd_t        SLEW_STEP  = 11'd8,
  parameter spd_t        ARM_MAX    = 11'd64
) (
  input logic                  clk,
  input logic                  rst_n,
  esc_arm_ramp_ctrl_if.slave   io_bus
);

  localparam int DWELL_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam int TICK_W  = (SLEW_DIV > 1)   ? $clog2(SLEW_DIV)   : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ARM_CYCLES - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SLEW_DIV - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DWELL_W-1:0]  r_dwell;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic                r_motors_off;
  logic                r_armed;
  logic                w_motors_off_nxt;
  logic                w_armed_nxt;

  spd_t                w_tgt_raw  [4];
  spd_t                w_slew_tgt [4];
  spd_t                w_spd      [4];
  logic                w_interlock_ok;
  logic                w_all_zero;
  logic                w_active;
  logic                w_active_nxt;
  logic                w_tick;
  logic                w_clr;

  always_comb begin
    w_tgt_raw[0] = io_bus.frnt_tgt;
    w_tgt_raw[1] = io_bus.bck_tgt;
    w_tgt_raw[2] = io_bus.lft_tgt;
    w_tgt_raw[3] = io_bus.rght_tgt;
  end

  assign w_interlock_ok = (w_tgt_raw[0] <= ARM_MAX) && (w_tgt_raw[1] <= ARM_MAX) &&
                          (w_tgt_raw[2] <= ARM_MAX) && (w_tgt_raw[3] <= ARM_MAX);
  assign w_all_zero     = (w_spd[0] == '0) && (w_spd[1] == '0) &&
                          (w_spd[2] == '0) && (w_spd[3] == '0);
  assign w_active       = (r_state == RUN) || (r_state == RAMP_DOWN);
  assign w_active_nxt   = (w_state_nxt == RUN) || (w_state_nxt == RAMP_DOWN);
  assign w_tick         = w_active && (r_tick_cnt == TICK_LAST);
  assign w_clr          = io_bus.kill || !w_active;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= DISARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (io_bus.kill) begin
      w_state_nxt = DISARMED;
    end else begin
      case (r_state)
        DISARMED:  if (io_bus.arm && w_interlock_ok) w_state_nxt = ARM_WAIT;
        ARM_WAIT: begin
          if (!io_bus.arm)               w_state_nxt = DISARMED;
          else if (r_dwell == DWELL_LAST) w_state_nxt = RUN;
        end
        RUN:       if (!io_bus.arm) w_state_nxt = RAMP_DOWN;
        RAMP_DOWN: begin
          if (io_bus.arm)      w_state_nxt = RUN;
          else if (w_all_zero) w_state_nxt = DISARMED;
        end
        default:   w_state_nxt = DISARMED;
      endcase
    end
  end

  // ---------------- FSM: output logic (registered below) ----------------
  always_comb begin
    w_motors_off_nxt = (w_state_nxt == DISARMED) || (w_state_nxt == ARM_WAIT);
    w_armed_nxt      = (w_state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_motors_off <= 1'b1;
      r_armed      <= 1'b0;
    end else begin
      r_motors_off <= w_motors_off_nxt;
      r_armed      <= w_armed_nxt;
    end
  end

  // Dwell restarts on every fresh entry to ARM_WAIT and idles at 0 elsewhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dwell <= '0;
    end else if ((r_state == ARM_WAIT) && (w_state_nxt == ARM_WAIT)) begin
      r_dwell <= r_dwell + DWELL_W'(1);
    end else begin
      r_dwell <= '0;
    end
  end

  // Tick phase survives RUN <-> RAMP_DOWN so re-arming does not stretch the slew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_active && w_active_nxt) begin
      r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + TICK_W'(1));
    end else begin
      r_tick_cnt <= '0;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_slew_tgt[i] = (r_state == RUN) ? w_tgt_raw[i] : '0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_motor
    slew_limiter #(
      .STEP (SLEW_STEP)
    ) u_slew (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_tick (w_tick),
      .i_clr  (w_clr),
      .i_tgt  (w_slew_tgt[g]),
      .o_spd  (w_spd[g])
    );
  end

  assign io_bus.frnt_spd   = w_spd[0];
  assign io_bus.bck_spd    = w_spd[1];
  assign io_bus.lft_spd    = w_spd[2];
  assign io_bus.rght_spd   = w_spd[3];
  assign io_bus.motors_off = r_motors_off;
  assign io_bus.armed      = r_armed;

endmodule

// File: tb/tb_esc_arm_ramp_ctrl.sv
// Self-checking bench for esc_arm_ramp_ctrl: vector table plus hand sequences,
// expected outputs queued at drive time and popped when sampled.
module tb_esc_arm_ramp_ctrl;
  import esc_ctrl_pkg::*;

  localparam int unsigned ARM_CYCLES = 20;
  localparam int unsigned SLEW_DIV   = 4;
  localparam spd_t        SLEW_STEP  = 11'd8;
  localparam spd_t        ARM_MAX    = 11'd64;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  esc_arm_ramp_ctrl_if bus ();

  esc_arm_ramp_ctrl #(
    .ARM_CYCLES (ARM_CYCLES),
    .SLEW_DIV   (SLEW_DIV),
    .SLEW_STEP  (SLEW_STEP),
    .ARM_MAX    (ARM_MAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  typedef struct {
    string name;
    logic  rst_n;
    logic  arm;
    logic  kill;
    spd_t  tgt;
    int    edges;
    spd_t  spd;
    logic  motors_off;
    logic  armed;
  } vec_t;

  typedef struct {
    string name;
    spd_t  spd;
    logic  motors_off;
    logic  armed;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic a, input logic k,
                              input spd_t tgt, input int edges, input spd_t spd,
                              input logic mo, input logic armed);
    vec_t v;
    v.name = n; v.rst_n = r; v.arm = a; v.kill = k; v.tgt = tgt; v.edges = edges;
    v.spd = spd; v.motors_off = mo; v.armed = armed;
    return v;
  endfunction

  task automatic drive(input logic r, input logic a, input logic k,
                       input spd_t t0, input spd_t t1, input spd_t t2, input spd_t t3);
    rst_n        = r;
    bus.arm      = a;
    bus.kill     = k;
    bus.frnt_tgt = t0;
    bus.bck_tgt  = t1;
    bus.lft_tgt  = t2;
    bus.rght_tgt = t3;
  endtask

  // Queue the expectation, let the design run, then compare away from the edge.
  task automatic expect_after(input string name, input int edges, input spd_t spd,
                              input logic mo, input logic armed);
    exp_t e;
    sb.push_back('{name, spd, mo, armed});
    repeat (edges) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, ".frnt_spd"},   32'(bus.frnt_spd),  32'(e.spd));
    check({e.name, ".bck_spd"},    32'(bus.bck_spd),   32'(e.spd));
    check({e.name, ".lft_spd"},    32'(bus.lft_spd),   32'(e.spd));
    check({e.name, ".rght_spd"},   32'(bus.rght_spd),  32'(e.spd));
    check({e.name, ".motors_off"}, 32'(bus.motors_off), 32'(e.motors_off));
    check({e.name, ".armed"},      32'(bus.armed),     32'(e.armed));
  endtask

  task automatic apply(input vec_t v);
    drive(v.rst_n, v.arm, v.kill, v.tgt, v.tgt, v.tgt, v.tgt);
    expect_after(v.name, v.edges, v.spd, v.motors_off, v.armed);
  endtask

  initial begin
    // name, rst_n, arm, kill, tgt, edges, exp spd, exp motors_off, exp armed
    vecs.push_back(mk("dwell_not_done",  1, 1, 0,  50,  20,   0, 1, 0));
    vecs.push_back(mk("run_entry",       1, 1, 0,  50,   1,   0, 0, 1));
    vecs.push_back(mk("pre_tick_hold",   1, 1, 0,  30,   3,   0, 0, 1));
    vecs.push_back(mk("slew_up_8",       1, 1, 0,  30,   1,   8, 0, 1));
    vecs.push_back(mk("slew_up_16",      1, 1, 0,  30,   4,  16, 0, 1));
    vecs.push_back(mk("slew_up_24",      1, 1, 0,  30,   4,  24, 0, 1));
    vecs.push_back(mk("slew_up_30",      1, 1, 0,  30,   4,  30, 0, 1));
    vecs.push_back(mk("hold_at_30",      1, 1, 0,  30,   4,  30, 0, 1));
    vecs.push_back(mk("disarm_enter",    1, 0, 0,  30,   1,  30, 0, 0));
    vecs.push_back(mk("ramp_22",         1, 0, 0,  30,   3,  22, 0, 0));
    vecs.push_back(mk("ramp_14",         1, 0, 0,  30,   4,  14, 0, 0));
    vecs.push_back(mk("ramp_6",          1, 0, 0,  30,   4,   6, 0, 0));
    vecs.push_back(mk("ramp_0",          1, 0, 0,  30,   4,   0, 0, 0));
    vecs.push_back(mk("ramp_done",       1, 0, 0,  30,   1,   0, 1, 0));
    vecs.push_back(mk("rearm_run",       1, 1, 0,  30,  21,   0, 0, 1));
    vecs.push_back(mk("rearm_up_30",     1, 1, 0,  30,  16,  30, 0, 1));
    vecs.push_back(mk("disarm2_enter",   1, 0, 0,  30,   1,  30, 0, 0));
    vecs.push_back(mk("ramp2_22",        1, 0, 0,  30,   3,  22, 0, 0));
    vecs.push_back(mk("ramp2_14",        1, 0, 0,  30,   4,  14, 0, 0));
    vecs.push_back(mk("midramp_rearm",   1, 1, 0,  30,   1,  14, 0, 1));
    vecs.push_back(mk("rearm_up_22",     1, 1, 0,  30,   3,  22, 0, 1));
    vecs.push_back(mk("rearm_up_30b",    1, 1, 0,  30,   4,  30, 0, 1));
    vecs.push_back(mk("climb_to_500",    1, 1, 0, 500, 236, 500, 0, 1));
    vecs.push_back(mk("kill",            1, 1, 1, 500,   1,   0, 1, 0));
    vecs.push_back(mk("post_kill_block", 1, 1, 0, 500,  25,   0, 1, 0));
    vecs.push_back(mk("arm_for_rev",     1, 1, 0,  40,  21,   0, 0, 1));
    vecs.push_back(mk("rise_to_24",      1, 1, 0,  40,  12,  24, 0, 1));
    vecs.push_back(mk("reverse_16",      1, 1, 0,   0,   4,  16, 0, 1));
    vecs.push_back(mk("reverse_8",       1, 1, 0,   0,   4,   8, 0, 1));
    vecs.push_back(mk("reset_midramp",   0, 1, 0,   0,   1,   0, 1, 0));
    vecs.push_back(mk("after_reset",     1, 0, 0,   0,   3,   0, 1, 0));

    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    expect_after("reset", 2, 0, 1'b1, 1'b0);

    // Interlock: one target above ARM_MAX must keep the block disarmed past the dwell.
    drive(1'b1, 1'b1, 1'b0, 11'd100, 11'd50, 11'd50, 11'd50);
    expect_after("interlock_block", 25, 0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Arm dropped mid-dwell, then re-armed with targets exactly at ARM_MAX:
    // the dwell must restart from zero.
    drive(1'b1, 1'b1, 1'b0, ARM_MAX, ARM_MAX, ARM_MAX, ARM_MAX);
    expect_after("dwell_partial", 10, 0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, ARM_MAX, ARM_MAX, ARM_MAX, ARM_MAX);
    expect_after("dwell_abort", 1, 0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, ARM_MAX, ARM_MAX, ARM_MAX, ARM_MAX);
    expect_after("dwell_restart", 20, 0, 1'b1, 1'b0);
    expect_after("boundary_run", 1, 0, 1'b0, 1'b1);

    // Disarm before any tick: speeds already zero, so RAMP_DOWN lasts one cycle.
    drive(1'b1, 1'b0, 1'b0, ARM_MAX, ARM_MAX, ARM_MAX, ARM_MAX);
    expect_after("zero_ramp_enter", 1, 0, 1'b0, 1'b0);
    expect_after("zero_ramp_exit", 1, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/esc_arm_ramp_ctrl.md
# esc_arm_ramp_ctrl

Arming and slew-rate sequencer that sits between the flight controller's four raw motor commands and the quad ESC block. It holds the motors off until an arm request passes the throttle interlock and an arming dwell. It then slew-limits each motor speed toward its commanded target. On disarm it ramps all motors down to zero before asserting `motors_off`. A kill input bypasses the ramp and forces an immediate stop.

## Interface
- `ARM_CYCLES`, 50_000_000: dwell in ARM_WAIT, in clk cycles (1 s @ 50 MHz).
- `SLEW_DIV`, 50_000: clk cycles per slew tick (1 ms @ 50 MHz).
- `SLEW_STEP`, 11'd8: maximum change per motor per slew tick.
- `ARM_MAX`, 11'd64: every target must be ≤ this value for arming to be accepted.

- `clk` input 1: system clock; the block's only clock.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `arm` input 1: level arm request.
- `kill` input 1: emergency stop, level-sensitive, highest priority.
- `frnt_tgt`, `bck_tgt`, `lft_tgt`, `rght_tgt` input 11 each: commanded speeds, unsigned.
- `frnt_spd`, `bck_spd`, `lft_spd`, `rght_spd` output 11 each: slew-limited speeds to the ESCs.
- `motors_off` output 1: 1 means ESCs are forced off.
- `armed` output 1: 1 in RUN only.

## Operation
- States:
  - DISARMED (reset state)
  - ARM_WAIT
  - RUN
  - RAMP_DOWN
- Transition priority, highest first: reset, then `kill`, then the per-state rules below.
- `kill`=1 in any state: next state is DISARMED; all `*_spd` cleared to 0 on the same edge.
- DISARMED → ARM_WAIT: `arm`=1 and all four targets ≤ `ARM_MAX`. Otherwise stay in DISARMED.
- ARM_WAIT:
  - `arm`=0 → DISARMED.
  - Dwell counter reaches `ARM_CYCLES`-1 → RUN.
  - Speeds held at 0.
- RUN:
  - On each slew tick, each speed moves toward its own target by min(`SLEW_STEP`, |target−spd|).
  - `arm`=0 → RAMP_DOWN.
- RAMP_DOWN:
  - Same slew rule, but every target is treated as 0.
  - `arm`=1 → RUN directly (no re-dwell, no interlock check).
  - All four speeds equal 0 → DISARMED.
- `motors_off` = 1 in DISARMED and ARM_WAIT, 0 in RUN and RAMP_DOWN.
- `armed` = 1 iff state is RUN.
- Arithmetic:
  - All values are 11-bit unsigned.
  - The difference is computed at 12 bits with its sign retained.
  - A step never overshoots the target, so no wrap-around is possible at 0 or at 2047.
- Target changes mid-ramp: the new target applies on the next tick; a reversal of direction is allowed.

## Timing
- All outputs are registered. Reset values:
  - `*_spd` = 0
  - `motors_off` = 1
  - `armed` = 0
  - state = DISARMED
  - both counters = 0
- Dwell counter:
  - Clears on entry to ARM_WAIT.
  - RUN is entered exactly `ARM_CYCLES` cycles after the DISARMED→ARM_WAIT edge.
- Tick counter:
  - Counts 0..`SLEW_DIV`-1 while in RUN or RAMP_DOWN; held at 0 in every other state.
  - A tick fires on the edge where the count wraps.
  - The first speed update occurs `SLEW_DIV` cycles after entering RUN.
  - The counter is not cleared on RAMP_DOWN↔RUN transitions.
- `kill`: speeds are 0 and `motors_off`=1 one edge after `kill` is sampled high.
- RAMP_DOWN→DISARMED: taken on the edge after all speeds read 0. `motors_off` rises on that same edge.
- Reset asserted mid-ramp: all outputs return to reset values on the next edge.

## Structure
- Package `esc_ctrl_pkg` holds:
  - the state enum (DISARMED, ARM_WAIT, RUN, RAMP_DOWN);
  - a `SPD_W`=11 constant;
  - a shared speed typedef.
- Sub-module `slew_limiter` is instanced four times. It takes `clk`, `rst_n`, `tick`, `clr`, and the target, and produces the registered speed.
- The top level owns the FSM, the dwell counter, the tick counter and the interlock compare.

## Test plan
- Arm interlock: `frnt_tgt`=100 with `arm`=1 → stays DISARMED, `motors_off`=1. Drop `frnt_tgt` to 50 → ARM_WAIT, then RUN after exactly `ARM_CYCLES` cycles. Use `ARM_CYCLES`=20 and `SLEW_DIV`=4 in the bench.
- Slew up: in RUN, all targets step to 30 with `SLEW_STEP`=8 → speeds go 8, 16, 24, 30 on successive ticks, 4 clk cycles apart.
- Disarm ramp: speeds at 30, then `arm`=0 → values 22, 14, 6, 0, then DISARMED and `motors_off`=1 on the following edge.
- Re-arm mid-ramp: `arm` reasserted when speeds are at 14 → RUN immediately, with no dwell, and ramp back up toward the targets.
- Kill: `kill`=1 while in RUN with speeds at 500 → next edge speeds = 0, `motors_off`=1, `armed`=0.
- Reversal and reset: target changes from 40 to 0 mid-rise, speed 24 → 16 on the next tick with no overshoot. Then `rst_n`=0 for one cycle → all outputs at reset values.
